// File: rtl/m_pipe_adder.sv
// rtl/m_pipe_adder.sv - parametrised pipelined ripple-carry adder/subtractor with valid/ready handshake
//
// Purpose:
//   WIDTH-bit add/subtract split into STAGES = WIDTH/SEG slices, one SEG-bit slice
//   per pipeline stage, carry registered between stages. Operand bits not yet
//   consumed are skewed forward stage by stage; finished result bits accumulate.
//   The whole pipeline advances together whenever the output can move.
//
// Optional feature:
//   M_PIPE_ADDER_OVF_EN - adds output V, signed overflow registered alongside S.
//
// Ports:
//   CLK        in   1      clock, rising edge
//   RST        in   1      synchronous active-high reset
//   IN_VALID   in   1      A/B/Cin/SUB valid
//   IN_READY   out  1      input accepted this cycle (= pipeline advance)
//   A, B       in   WIDTH  operands
//   Cin        in   1      carry-in, ignored when SUB=1
//   SUB        in   1      1: S = A - B, 0: S = A + B + Cin
//   OUT_VALID  out  1      S/Cout valid
//   OUT_READY  in   1      downstream accepts result
//   S          out  WIDTH  sum/difference
//   Cout       out  1      carry-out (for SUB: 1 = no borrow)
//   V          out  1      signed overflow (only with M_PIPE_ADDER_OVF_EN)

module m_pipe_adder #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             SUB,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] S,
    output logic             Cout
`ifdef M_PIPE_ADDER_OVF_EN
    ,
    output logic             V
`endif
);

    localparam int STAGES = WIDTH / SEG;

    if ((WIDTH % SEG) != 0 || STAGES < 1) begin : g_bad_cfg
        $error("m_pipe_adder: WIDTH must be a non-zero multiple of SEG");
    end

    // Every stage moves on the same condition, so a stalled output freezes the
    // whole pipe and nothing can be overwritten.
    logic adv;
    assign adv      = !OUT_VALID || OUT_READY;
    assign IN_READY = adv;

    // Subtraction is A + ~B + 1; Cin is replaced by the forced 1.
    logic [WIDTH-1:0] b_eff;
    logic             c_first;
    assign b_eff   = SUB ? ~B : B;
    assign c_first = SUB ? 1'b1 : Cin;

    genvar k;
    for (k = 0; k < STAGES; k++) begin : g_st
        logic [SEG-1:0]       a_sl;
        logic [SEG-1:0]       b_sl;
        logic                 c_in;
        logic                 v_in;
        logic [SEG:0]         slice;
        logic [(k+1)*SEG-1:0] sum_d;
        logic [(k+1)*SEG-1:0] sum_q;
        logic                 vld_q;
        logic                 cry_q;

        if (k == 0) begin : g_in
            assign a_sl  = A[SEG-1:0];
            assign b_sl  = b_eff[SEG-1:0];
            assign c_in  = c_first;
            assign v_in  = IN_VALID;
            assign sum_d = slice[SEG-1:0];
        end else begin : g_in
            // Lowest remaining skewed operand bits belong to this stage's slice.
            assign a_sl  = g_st[k-1].g_hi.hi_a[SEG-1:0];
            assign b_sl  = g_st[k-1].g_hi.hi_b[SEG-1:0];
            assign c_in  = g_st[k-1].cry_q;
            assign v_in  = g_st[k-1].vld_q;
            assign sum_d = {slice[SEG-1:0], g_st[k-1].sum_q};
        end

        assign slice = {1'b0, a_sl} + {1'b0, b_sl} + {{SEG{1'b0}}, c_in};

        always_ff @(posedge CLK) begin
            if (RST) begin
                vld_q <= 1'b0;
                cry_q <= 1'b0;
                sum_q <= '0;
            end else if (adv) begin
                vld_q <= v_in;
                cry_q <= slice[SEG];
                sum_q <= sum_d;
            end
        end

        // Operand bits for the slices still ahead; the last stage needs none.
        if (k < STAGES - 1) begin : g_hi
            localparam int HW = WIDTH - (k + 1) * SEG;
            logic [HW-1:0] hi_a_d;
            logic [HW-1:0] hi_b_d;
            logic [HW-1:0] hi_a;
            logic [HW-1:0] hi_b;

            if (k == 0) begin : g_src
                assign hi_a_d = A[WIDTH-1:SEG];
                assign hi_b_d = b_eff[WIDTH-1:SEG];
            end else begin : g_src
                assign hi_a_d = g_st[k-1].g_hi.hi_a[WIDTH-k*SEG-1:SEG];
                assign hi_b_d = g_st[k-1].g_hi.hi_b[WIDTH-k*SEG-1:SEG];
            end

            always_ff @(posedge CLK) begin
                if (RST) begin
                    hi_a <= '0;
                    hi_b <= '0;
                end else if (adv) begin
                    hi_a <= hi_a_d;
                    hi_b <= hi_b_d;
                end
            end
        end
    end

    assign S         = g_st[STAGES-1].sum_q;
    assign Cout      = g_st[STAGES-1].cry_q;
    assign OUT_VALID = g_st[STAGES-1].vld_q;

`ifdef M_PIPE_ADDER_OVF_EN
    // Carry into the MSB is recovered from the MSB sum bit: sum = a ^ b ^ cin.
    logic ovf_d;
    logic ovf_q;
    assign ovf_d = (g_st[STAGES-1].slice[SEG-1] ^ g_st[STAGES-1].a_sl[SEG-1]
                    ^ g_st[STAGES-1].b_sl[SEG-1]) ^ g_st[STAGES-1].slice[SEG];

    always_ff @(posedge CLK) begin
        if (RST) begin
            ovf_q <= 1'b0;
        end else if (adv) begin
            ovf_q <= ovf_d;
        end
    end

    assign V = ovf_q;
`endif

endmodule

// File: tb/tb_m_pipe_adder.sv
// tb/tb_m_pipe_adder.sv - self-checking bench for m_pipe_adder (WIDTH=16, SEG=4)

module tb_m_pipe_adder;

    localparam int ST = 4;
    localparam int NV = 10;

    logic        CLK = 1'b0;
    logic        RST;
    logic        IN_VALID;
    logic        IN_READY;
    logic [15:0] A;
    logic [15:0] B;
    logic        Cin;
    logic        SUB;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [15:0] S;
    logic        Cout;
`ifdef M_PIPE_ADDER_OVF_EN
    logic        V;
`endif

    always #5 CLK = ~CLK;

    m_pipe_adder #(.WIDTH(16), .SEG(4)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .SUB       (SUB),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .S         (S),
        .Cout      (Cout)
`ifdef M_PIPE_ADDER_OVF_EN
        ,
        .V         (V)
`endif
    );

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        v;
    } res_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] s;
        logic        c;
    } vec_t;

    vec_t tv[NV];
    res_t sbq[$];

    int n_chk = 0;
    int n_fail = 0;
    int cyc_no = 0;
    int pop_cnt = 0;
    int first_pop = 0;
    int last_pop = 0;

    logic        smp_ov;
    logic        smp_ir;
    logic        smp_c;
    logic        smp_v;
    logic [15:0] smp_s;

    // Reference: plain integer arithmetic on the operation's meaning.
    function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic ci, input logic sb);
        res_t        r;
        logic [16:0] u;
        int          ia;
        int          ib;
        int          t;
        ia = int'($signed(a));
        ib = int'($signed(b));
        if (sb) begin
            r.s = a - b;
            r.c = (a >= b);
            t   = ia - ib;
        end else begin
            u   = {1'b0, a} + {1'b0, b} + {16'd0, ci};
            r.s = u[15:0];
            r.c = u[16];
            t   = ia + ib + int'(ci);
        end
        r.v = (t > 32767) || (t < -32768);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_no);
        end
    endtask

    // One clock cycle: drive at negedge, sample 1ns before the rising edge.
    task automatic cyc(input logic v, input logic [15:0] a, input logic [15:0] b,
                       input logic ci, input logic sb, input logic ordy);
        res_t e;
        IN_VALID  = v;
        A         = a;
        B         = b;
        Cin       = ci;
        SUB       = sb;
        OUT_READY = ordy;
        #4;
        smp_ov = OUT_VALID;
        smp_ir = IN_READY;
        smp_s  = S;
        smp_c  = Cout;
`ifdef M_PIPE_ADDER_OVF_EN
        smp_v  = V;
`else
        smp_v  = 1'b0;
`endif
        chk("in_ready_rule", 32'(IN_READY), 32'(!OUT_VALID || OUT_READY));
        if (OUT_VALID && OUT_READY) begin
            if (sbq.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_output: got S=%h with nothing pending (cycle %0d)", S, cyc_no);
            end else begin
                e = sbq.pop_front();
                chk("out_s", 32'(S), 32'(e.s));
                chk("out_cout", 32'(Cout), 32'(e.c));
`ifdef M_PIPE_ADDER_OVF_EN
                chk("out_v", 32'(V), 32'(e.v));
`endif
                pop_cnt++;
                if (pop_cnt == 1) first_pop = cyc_no;
                last_pop = cyc_no;
            end
        end
        if (IN_VALID && IN_READY) sbq.push_back(model(a, b, ci, sb));
        @(negedge CLK);
        cyc_no++;
    endtask

    // Single transaction into an idle pipe; reports cycles until OUT_VALID.
    task automatic run_one(input logic [15:0] a, input logic [15:0] b, input logic ci,
                           input logic sb, output int lat, output logic [15:0] gs,
                           output logic gc, output logic gv);
        lat = 0;
        gs  = '0;
        gc  = 1'b0;
        gv  = 1'b0;
        cyc(1'b1, a, b, ci, sb, 1'b1);
        for (int n = 1; n <= 8; n++) begin
            cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
            if (smp_ov && lat == 0) begin
                lat = n;
                gs  = smp_s;
                gc  = smp_c;
                gv  = smp_v;
            end
        end
    endtask

    task automatic drain(input int budget);
        for (int n = 0; n < budget && sbq.size() > 0; n++)
            cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
        chk("drain_empty", 32'(sbq.size()), 32'd0);
    endtask

    initial begin
        int          lat;
        logic [15:0] gs;
        logic        gc;
        logic        gv;
        logic [15:0] held;

        tv[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1};
        tv[1] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0};
        tv[2] = '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1};
        tv[3] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0};
        tv[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1};
        tv[5] = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0};
        tv[6] = '{16'h8000, 16'h8000, 1'b0, 1'b1, 16'h0000, 1'b1};
        tv[7] = '{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0};
        tv[8] = '{16'h00FF, 16'h0001, 1'b1, 1'b1, 16'h00FE, 1'b1};
        tv[9] = '{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0};

        RST = 1'b1; IN_VALID = 1'b0; A = '0; B = '0; Cin = 1'b0; SUB = 1'b0; OUT_READY = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        #4;
        chk("rst_out_valid", 32'(OUT_VALID), 32'd0);
        chk("rst_s", 32'(S), 32'd0);
        chk("rst_cout", 32'(Cout), 32'd0);
        chk("rst_in_ready", 32'(IN_READY), 32'd1);
`ifdef M_PIPE_ADDER_OVF_EN
        chk("rst_v", 32'(V), 32'd0);
`endif
        @(negedge CLK);

        // Directed vectors: latency and result against constants.
        for (int i = 0; i < NV; i++) begin
            run_one(tv[i].a, tv[i].b, tv[i].cin, tv[i].sub, lat, gs, gc, gv);
            chk($sformatf("tv%0d_latency", i), 32'(lat), 32'(ST));
            chk($sformatf("tv%0d_s", i), 32'(gs), 32'(tv[i].s));
            chk($sformatf("tv%0d_cout", i), 32'(gc), 32'(tv[i].c));
        end

        // Eight back-to-back random transactions: one result per cycle, in order.
        pop_cnt = 0;
        for (int i = 0; i < 8; i++)
            cyc(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0, 1'b1);
        drain(20);
        chk("stream_count", 32'(pop_cnt), 32'd8);
        chk("stream_spacing", 32'(last_pop - first_pop), 32'd7);

        // Backpressure: stall output for 3 cycles from the first OUT_VALID.
        pop_cnt = 0;
        for (int i = 0; i < 4; i++)
            cyc(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1);
        held = (sbq.size() > 0) ? sbq[0].s : 16'h0;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 16'hABCD, 16'h1111, 1'b0, 1'b0, 1'b0);
            chk("stall_out_valid", 32'(smp_ov), 32'd1);
            chk("stall_in_ready", 32'(smp_ir), 32'd0);
            chk("stall_s_held", 32'(smp_s), 32'(held));
        end
        chk("stall_no_pop", 32'(pop_cnt), 32'd0);
        drain(20);
        chk("stall_count", 32'(pop_cnt), 32'd4);

        // Reset with two transactions in flight: nothing may emerge afterwards.
        cyc(1'b1, 16'h1357, 16'h2468, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 16'h9999, 16'h0001, 1'b0, 1'b1, 1'b1);
        RST = 1'b1;
        IN_VALID = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        sbq.delete();
        #4;
        chk("midrst_out_valid", 32'(OUT_VALID), 32'd0);
        chk("midrst_s", 32'(S), 32'd0);
        chk("midrst_cout", 32'(Cout), 32'd0);
        @(negedge CLK);
        pop_cnt = 0;
        for (int i = 0; i < 8; i++)
            cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
        chk("midrst_no_stale", 32'(pop_cnt), 32'd0);

        // Random traffic with random bubbles and backpressure.
        pop_cnt = 0;
        for (int i = 0; i < 300; i++)
            cyc(($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom), 1'($urandom),
                1'($urandom), ($urandom_range(0, 2) != 0));
        drain(40);

`ifdef M_PIPE_ADDER_OVF_EN
        run_one(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat, gs, gc, gv);
        chk("ovf1_s", 32'(gs), 32'h8000);
        chk("ovf1_v", 32'(gv), 32'd1);
        run_one(16'h8000, 16'h0001, 1'b0, 1'b1, lat, gs, gc, gv);
        chk("ovf2_s", 32'(gs), 32'h7FFF);
        chk("ovf2_v", 32'(gv), 32'd1);
        run_one(16'h0001, 16'h0001, 1'b0, 1'b0, lat, gs, gc, gv);
        chk("ovf3_s", 32'(gs), 32'h0002);
        chk("ovf3_v", 32'(gv), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
